mem_rr_arbiter: RTL and testbench
=================================

// Module: mem_rr_arbiter
// PURPOSE
//   Two-requester round-robin arbiter/sequencer for the 16x8 single-port RAM (sync read, 1-cycle
//   read latency, write on posedge when we=1). Issues at most one access per cycle and registers
//   the RAM-side address, write data and write enable. Returns read data to the requester that
//   issued the read, tagged with a one-cycle rvalid pulse. Sits between two bus masters and the
//   RAM's adr/dat_w/we/dat_r ports.
// PARAMETERS
//   AW  4  address width (RAM depth = 2**AW)
//   DW  8  data width
// PORTS
//   clk        in   1   single clock, all logic on posedge
//   rst        in   1   asynchronous, active-high reset
//   r0_req     in   1   requester 0 access request (level, held until granted)
//   r0_we      in   1   1 = write, 0 = read
//   r0_adr     in   AW  requester 0 address
//   r0_dat_w   in   DW  requester 0 write data
//   r0_gnt     out  1   1-cycle pulse: request accepted
//   r0_rvalid  out  1   1-cycle pulse: r0_dat_r holds read result
//   r0_dat_r   out  DW  read data (held until next r0 read completes)
//   r1_*       --   --  identical set for requester 1
//   mem_adr    out  AW  to RAM adr (registered)
//   mem_dat_w  out  DW  to RAM dat_w (registered)
//   mem_we     out  1   to RAM we (registered)
//   mem_dat_r  in   DW  from RAM dat_r
//   last_gnt   out  1   id of the most recently granted requester (round-robin pointer)
// BEHAVIOUR
//   - Reset (async, rst=1): all gnt/rvalid=0, rX_dat_r=0, mem_adr=0, mem_dat_w=0, mem_we=0,
//     last_gnt=1 (r0 wins first tie), read-tag pipeline cleared. In-flight reads are dropped:
//     no rvalid is ever produced for a request granted before reset.
//   - Eligibility at edge E: rX_req=1 AND rX_gnt=0 (a requester whose gnt is high at E is masked,
//     so a held req is never issued twice; requester drops req or presents next op in gnt cycle).
//   - Arbitration at E: none eligible -> idle (mem_we<=0, mem_adr/mem_dat_w hold). One eligible ->
//     grant it. Both -> grant requester != last_gnt. last_gnt updates only on a grant.
//   - On grant at E: rX_gnt<=1 for one cycle; mem_adr<=rX_adr, mem_dat_w<=rX_dat_w, mem_we<=rX_we.
//     RAM performs write / latches read address at E+1. Idle or reads: mem_we<=0.
//   - Read return: tag {valid,id} pipelined 2 stages. At E+2 rID_dat_r<=mem_dat_r and rID_rvalid
//     pulses for the cycle after E+2. Read latency = 3 edges from req sampling to rvalid visible.
//     Writes produce no rvalid.
//   - Throughput: 1 access/cycle total; single requester alone: 1 access per 2 cycles.
//   - Ordering: RAM accesses in grant order; read after write to same address (any requester)
//     returns the new data if write granted in an earlier cycle.
//   - Simultaneous rvalid on both requesters impossible (one issue per cycle).
//   - Address wraps naturally in AW bits; no out-of-range handling.
// TESTING (bench instantiates RAM with init image; mem[0]=8'h90, mem[3]=8'hFE, mem[15]=8'h98)
//   1. Reset, r0 read adr=3 -> r0_gnt 1 cycle after req edge; r0_rvalid with r0_dat_r=8'hFE 3 edges
//      after req edge; r1 outputs quiet.
//   2. r0 and r1 both read (adr 0 / adr 15) held continuously after reset -> grants r0,r1,r0,r1...;
//      r0 gets 8'h90, r1 gets 8'h98, one rvalid per cycle alternating, last_gnt toggles.
//   3. r1 write adr=5 data=8'hA5, next cycle r0 read adr=5 -> r0_dat_r=8'hA5 (not 8'h4F).
//   4. r0 holds req with gnt visible -> exactly one RAM access per grant, no duplicate write.
//   5. rst asserted one cycle after read grant -> outputs zero immediately, no rvalid after release;
//      first tie after release grants r0.
//   6. Idle cycles between requests -> mem_we=0 throughout idle, no spurious gnt/rvalid.

Source files
------------

// File: rtl/mem_rr_arbiter.sv
// mem_rr_arbiter
//   Round-robin arbiter/sequencer that lets two bus masters share one
//   single-port synchronous RAM (1-cycle read latency). At most one access is
//   issued per cycle. RAM address, write data and write enable are registered.
//   Read data is routed back to the requester that issued the read, marked by a
//   one-cycle rvalid pulse.
//
//   Ports
//     clk, rst                 clock, asynchronous active-high reset
//     rX_req/we/adr/dat_w      requester X access request (X = 0, 1)
//     rX_gnt                   1-cycle pulse: request accepted
//     rX_rvalid, rX_dat_r      read return pulse and held read data
//     mem_adr/dat_w/we         registered RAM-side controls
//     mem_dat_r                RAM read data
//     last_gnt                 id of the most recently granted requester
module mem_rr_arbiter #(
  parameter int AW = 4,
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_adr,
  input  logic [DW-1:0] r0_dat_w,
  output logic          r0_gnt,
  output logic          r0_rvalid,
  output logic [DW-1:0] r0_dat_r,
  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_adr,
  input  logic [DW-1:0] r1_dat_w,
  output logic          r1_gnt,
  output logic          r1_rvalid,
  output logic [DW-1:0] r1_dat_r,
  output logic [AW-1:0] mem_adr,
  output logic [DW-1:0] mem_dat_w,
  output logic          mem_we,
  input  logic [DW-1:0] mem_dat_r,
  output logic          last_gnt
);

  logic          elig0, elig1, grant, sel;
  logic          sel_we;
  logic [AW-1:0] sel_adr;
  logic [DW-1:0] sel_dat_w;

  // Read-return tag pipeline: stage 1 travels with the RAM address cycle,
  // stage 2 with the RAM data cycle.
  logic tag1_v, tag1_id, tag2_v, tag2_id;

  always_comb begin
    // A requester whose gnt is high this cycle is masked so a held request
    // is never issued twice.
    elig0 = r0_req & ~r0_gnt;
    elig1 = r1_req & ~r1_gnt;
    grant = elig0 | elig1;
    if (elig0 && elig1) sel = ~last_gnt;
    else                sel = elig1;
    sel_we    = sel ? r1_we    : r0_we;
    sel_adr   = sel ? r1_adr   : r0_adr;
    sel_dat_w = sel ? r1_dat_w : r0_dat_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      r0_dat_r  <= '0;
      r1_dat_r  <= '0;
      mem_adr   <= '0;
      mem_dat_w <= '0;
      mem_we    <= 1'b0;
      last_gnt  <= 1'b1;
      tag1_v    <= 1'b0;
      tag1_id   <= 1'b0;
      tag2_v    <= 1'b0;
      tag2_id   <= 1'b0;
    end else begin
      r0_gnt <= grant & ~sel;
      r1_gnt <= grant & sel;
      if (grant) begin
        last_gnt  <= sel;
        mem_adr   <= sel_adr;
        mem_dat_w <= sel_dat_w;
        mem_we    <= sel_we;
      end else begin
        mem_we <= 1'b0;
      end

      tag1_v  <= grant & ~sel_we;
      tag1_id <= sel;
      tag2_v  <= tag1_v;
      tag2_id <= tag1_id;

      r0_rvalid <= tag2_v & ~tag2_id;
      r1_rvalid <= tag2_v & tag2_id;
      if (tag2_v && !tag2_id) r0_dat_r <= mem_dat_r;
      if (tag2_v &&  tag2_id) r1_dat_r <= mem_dat_r;
    end
  end

endmodule

// File: tb/tb_mem_rr_arbiter.sv
// tb_mem_rr_arbiter
//   Directed bench for mem_rr_arbiter with a behavioural 16x8 sync-read RAM.
//   Inputs are driven 1 time unit after the rising edge; outputs are sampled
//   at the same point, after the edge has settled.
module tb_mem_rr_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       r0_req, r0_we, r1_req, r1_we;
  logic [3:0] r0_adr, r1_adr;
  logic [7:0] r0_dat_w, r1_dat_w;
  logic       r0_gnt, r0_rvalid, r1_gnt, r1_rvalid;
  logic [7:0] r0_dat_r, r1_dat_r;
  logic [3:0] mem_adr;
  logic [7:0] mem_dat_w, mem_dat_r;
  logic       mem_we, last_gnt;

  int unsigned n_checks = 0;
  int unsigned n_fails  = 0;
  int unsigned gnt_cnt, we_cnt;

  logic [7:0] ram [16] = '{8'h90, 8'h4B, 8'h4C, 8'hFE, 8'h4E, 8'h4F, 8'h50, 8'h51,
                           8'h52, 8'h53, 8'h54, 8'h55, 8'h56, 8'h57, 8'h58, 8'h98};

  always #5 clk = ~clk;

  // Single-port RAM: write on we, synchronous read with 1-cycle latency.
  always @(posedge clk) begin
    if (mem_we) ram[mem_adr] <= mem_dat_w;
    mem_dat_r <= ram[mem_adr];
  end

  mem_rr_arbiter #(.AW(4), .DW(8)) dut (
    .clk(clk), .rst(rst),
    .r0_req(r0_req), .r0_we(r0_we), .r0_adr(r0_adr), .r0_dat_w(r0_dat_w),
    .r0_gnt(r0_gnt), .r0_rvalid(r0_rvalid), .r0_dat_r(r0_dat_r),
    .r1_req(r1_req), .r1_we(r1_we), .r1_adr(r1_adr), .r1_dat_w(r1_dat_w),
    .r1_gnt(r1_gnt), .r1_rvalid(r1_rvalid), .r1_dat_r(r1_dat_r),
    .mem_adr(mem_adr), .mem_dat_w(mem_dat_w), .mem_we(mem_we),
    .mem_dat_r(mem_dat_r), .last_gnt(last_gnt)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, " r0_gnt"},    32'(r0_gnt),    0);
    check_eq({tag, " r1_gnt"},    32'(r1_gnt),    0);
    check_eq({tag, " r0_rvalid"}, 32'(r0_rvalid), 0);
    check_eq({tag, " r1_rvalid"}, 32'(r1_rvalid), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected end of test");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    r0_req = 0; r0_we = 0; r0_adr = 0; r0_dat_w = 0;
    r1_req = 0; r1_we = 0; r1_adr = 0; r1_dat_w = 0;
    tick(); tick();

    // Reset state
    check_quiet("rst");
    check_eq("rst r0_dat_r", 32'(r0_dat_r), 0);
    check_eq("rst r1_dat_r", 32'(r1_dat_r), 0);
    check_eq("rst mem_adr", 32'(mem_adr), 0);
    check_eq("rst mem_dat_w", 32'(mem_dat_w), 0);
    check_eq("rst mem_we", 32'(mem_we), 0);
    check_eq("rst last_gnt", 32'(last_gnt), 1);
    rst = 1'b0;
    tick();

    // 1: single read of adr 3
    r0_req = 1; r0_we = 0; r0_adr = 4'd3;
    tick();
    check_eq("t1 r0_gnt", 32'(r0_gnt), 1);
    check_eq("t1 r1_gnt", 32'(r1_gnt), 0);
    check_eq("t1 mem_adr", 32'(mem_adr), 3);
    check_eq("t1 mem_we", 32'(mem_we), 0);
    check_eq("t1 last_gnt", 32'(last_gnt), 0);
    r0_req = 0;
    tick();
    check_quiet("t1 e+1");
    tick();
    check_eq("t1 r0_rvalid", 32'(r0_rvalid), 1);
    check_eq("t1 r0_dat_r", 32'(r0_dat_r), 32'hFE);
    check_eq("t1 r1_rvalid", 32'(r1_rvalid), 0);
    check_eq("t1 r1_dat_r", 32'(r1_dat_r), 0);
    tick();
    check_quiet("t1 e+3");
    check_eq("t1 r0_dat_r hold", 32'(r0_dat_r), 32'hFE);

    // 2: both read continuously after reset, alternate grants
    rst = 1'b1; tick(); rst = 1'b0;
    r0_req = 1; r0_we = 0; r0_adr = 4'd0;
    r1_req = 1; r1_we = 0; r1_adr = 4'd15;
    for (int k = 0; k < 8; k++) begin
      tick();
      check_eq($sformatf("t2 r0_gnt %0d", k), 32'(r0_gnt), (k % 2 == 0) ? 1 : 0);
      check_eq($sformatf("t2 r1_gnt %0d", k), 32'(r1_gnt), (k % 2 == 1) ? 1 : 0);
      check_eq($sformatf("t2 last_gnt %0d", k), 32'(last_gnt), (k % 2 == 1) ? 1 : 0);
      check_eq($sformatf("t2 mem_adr %0d", k), 32'(mem_adr), (k % 2 == 0) ? 0 : 15);
      if (k >= 2) begin
        check_eq($sformatf("t2 r0_rvalid %0d", k), 32'(r0_rvalid), (k % 2 == 0) ? 1 : 0);
        check_eq($sformatf("t2 r1_rvalid %0d", k), 32'(r1_rvalid), (k % 2 == 1) ? 1 : 0);
        check_eq($sformatf("t2 r0_dat_r %0d", k), 32'(r0_dat_r), 32'h90);
        check_eq($sformatf("t2 r1_dat_r %0d", k), 32'(r1_dat_r), (k == 2) ? 0 : 32'h98);
      end
    end
    r0_req = 0; r1_req = 0;
    tick(); tick(); tick(); tick();
    check_quiet("t2 drained");

    // 3: r1 write adr 5, then r0 read adr 5 sees the new data
    r1_req = 1; r1_we = 1; r1_adr = 4'd5; r1_dat_w = 8'hA5;
    tick();
    check_eq("t3 r1_gnt", 32'(r1_gnt), 1);
    check_eq("t3 mem_we", 32'(mem_we), 1);
    check_eq("t3 mem_adr", 32'(mem_adr), 5);
    check_eq("t3 mem_dat_w", 32'(mem_dat_w), 32'hA5);
    r1_req = 0; r1_we = 0;
    r0_req = 1; r0_we = 0; r0_adr = 4'd5;
    tick();
    check_eq("t3 r0_gnt", 32'(r0_gnt), 1);
    check_eq("t3 mem_we rd", 32'(mem_we), 0);
    r0_req = 0;
    tick();
    check_quiet("t3 e+2");
    tick();
    check_eq("t3 r0_rvalid", 32'(r0_rvalid), 1);
    check_eq("t3 r0_dat_r", 32'(r0_dat_r), 32'hA5);
    check_eq("t3 r1_rvalid", 32'(r1_rvalid), 0);
    tick();

    // 4a: held write, next op presented in gnt cycle
    r0_req = 1; r0_we = 1; r0_adr = 4'd7; r0_dat_w = 8'h3C;
    tick();
    check_eq("t4 gnt a", 32'(r0_gnt), 1);
    check_eq("t4 we a", 32'(mem_we), 1);
    r0_adr = 4'd8; r0_dat_w = 8'h3D;
    tick();
    check_eq("t4 gnt masked", 32'(r0_gnt), 0);
    check_eq("t4 we masked", 32'(mem_we), 0);
    tick();
    check_eq("t4 gnt b", 32'(r0_gnt), 1);
    check_eq("t4 we b", 32'(mem_we), 1);
    check_eq("t4 adr b", 32'(mem_adr), 8);
    check_eq("t4 dat b", 32'(mem_dat_w), 32'h3D);
    // 4b: hold the same write for 6 cycles -> 3 grants, 3 writes
    r0_adr = 4'd9; r0_dat_w = 8'h77;
    gnt_cnt = 0; we_cnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      check_eq($sformatf("t4 we==gnt %0d", k), 32'(mem_we), 32'(r0_gnt));
      gnt_cnt += 32'(r0_gnt);
      we_cnt  += 32'(mem_we);
    end
    r0_req = 0; r0_we = 0;
    tick(); tick();
    check_eq("t4 gnt count", gnt_cnt, 3);
    check_eq("t4 we count", we_cnt, 3);
    check_eq("t4 ram[7]", 32'(ram[7]), 32'h3C);
    check_eq("t4 ram[8]", 32'(ram[8]), 32'h3D);
    check_eq("t4 ram[9]", 32'(ram[9]), 32'h77);
    check_quiet("t4 end");

    // 5: reset one cycle after a read grant
    r0_req = 1; r0_adr = 4'd3;
    tick();
    check_eq("t5 r0_gnt", 32'(r0_gnt), 1);
    r0_req = 0;
    tick();
    rst = 1'b1;
    #1;
    check_quiet("t5 in rst");
    check_eq("t5 r0_dat_r", 32'(r0_dat_r), 0);
    check_eq("t5 mem_adr", 32'(mem_adr), 0);
    check_eq("t5 last_gnt", 32'(last_gnt), 1);
    tick();
    rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_quiet($sformatf("t5 post %0d", k));
    end
    r0_req = 1; r0_adr = 4'd0; r1_req = 1; r1_adr = 4'd15; r1_we = 0;
    tick();
    check_eq("t5 tie r0_gnt", 32'(r0_gnt), 1);
    check_eq("t5 tie r1_gnt", 32'(r1_gnt), 0);
    r0_req = 0; r1_req = 0;
    tick(); tick();
    check_eq("t5 r0_rvalid", 32'(r0_rvalid), 1);
    check_eq("t5 r0_dat_r", 32'(r0_dat_r), 32'h90);
    tick();

    // 6: idle cycles
    for (int k = 0; k < 5; k++) begin
      tick();
      check_quiet($sformatf("t6 idle %0d", k));
      check_eq($sformatf("t6 mem_we %0d", k), 32'(mem_we), 0);
      check_eq($sformatf("t6 mem_adr %0d", k), 32'(mem_adr), 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
